// File: rtl/histogram_denetleyici_pkg.sv
// Shared constants and state encoding for the histogram frame sequencer.
package histogram_denetleyici_pkg;

  typedef enum logic [2:0] {
    StBosta   = 3'd0,
    StTemizle = 3'd1,
    StHrst    = 3'd2,
    StTopla   = 3'd3,
    StBosalt  = 3'd4,
    StTara    = 3'd5,
    StBitti   = 3'd6
  } durum_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int unsigned PIXEL_BIT_VARSAYILAN    = 8;
  localparam int unsigned SAYAC_BIT_VARSAYILAN    = 17;
  localparam int unsigned PIXEL_SAYISI_VARSAYILAN = 76800;

endpackage

// File: rtl/histogram_denetleyici_tara_birimi.sv
// CDF scan: sequential reads of all bins, saturating running sum, in-place write-back.
module histogram_denetleyici_tara_birimi
  import histogram_denetleyici_pkg::*;
#(
  parameter int unsigned PIXEL_BIT = PIXEL_BIT_VARSAYILAN,
  parameter int unsigned SAYAC_BIT = SAYAC_BIT_VARSAYILAN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_baslat,
  input  logic [SAYAC_BIT-1:0] i_ram_veri,
  output logic                 o_ram_rd_en,
  output logic [PIXEL_BIT-1:0] o_ram_addr_r,
  output logic                 o_ram_wr_en,
  output logic [PIXEL_BIT-1:0] o_ram_addr_w,
  output logic [SAYAC_BIT-1:0] o_ram_data,
  output logic                 o_cdf_gecerli,
  output logic [PIXEL_BIT-1:0] o_cdf_adres,
  output logic [SAYAC_BIT-1:0] o_cdf_deger,
  output logic                 o_bitti
);

  logic                 r_okuma_aktif;
  logic [PIXEL_BIT-1:0] r_okuma_adres;
  logic                 r_veri_gecerli;
  logic [PIXEL_BIT-1:0] r_veri_adres;
  logic                 r_cdf_gecerli;
  logic [PIXEL_BIT-1:0] r_cdf_adres;
  logic [SAYAC_BIT-1:0] r_toplam;

  logic [SAYAC_BIT:0]   w_toplam_genis;
  logic [SAYAC_BIT-1:0] w_toplam_doyumlu;

  assign w_toplam_genis   = {1'b0, r_toplam} + {1'b0, i_ram_veri};
  assign w_toplam_doyumlu = w_toplam_genis[SAYAC_BIT] ? '1 : w_toplam_genis[SAYAC_BIT-1:0];

  // Read at cycle n, RAM data at n+1, registered CDF at n+2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_okuma_aktif  <= LOW;
      r_okuma_adres  <= '0;
      r_veri_gecerli <= LOW;
      r_veri_adres   <= '0;
      r_cdf_gecerli  <= LOW;
      r_cdf_adres    <= '0;
      r_toplam       <= '0;
    end else begin
      r_veri_gecerli <= r_okuma_aktif;
      r_veri_adres   <= r_okuma_adres;
      r_cdf_gecerli  <= r_veri_gecerli;
      if (i_baslat) begin
        r_okuma_aktif <= HIGH;
        r_okuma_adres <= '0;
        r_toplam      <= '0;
      end else if (r_okuma_aktif) begin
        r_okuma_adres <= r_okuma_adres + 1'b1;
        if (r_okuma_adres == '1) begin
          r_okuma_aktif <= LOW;
        end
      end
      if (r_veri_gecerli) begin
        r_toplam    <= w_toplam_doyumlu;
        r_cdf_adres <= r_veri_adres;
      end
    end
  end

  assign o_ram_rd_en   = ~r_okuma_aktif;
  assign o_ram_addr_r  = r_okuma_adres;
  assign o_ram_wr_en   = ~r_cdf_gecerli;
  assign o_ram_addr_w  = r_cdf_adres;
  assign o_ram_data    = r_toplam;
  assign o_cdf_gecerli = r_cdf_gecerli;
  assign o_cdf_adres   = r_cdf_adres;
  assign o_cdf_deger   = r_toplam;
  assign o_bitti       = r_cdf_gecerli && (r_cdf_adres == '1);

endmodule

// File: rtl/histogram_denetleyici.sv
// Frame sequencer and histogram RAM port owner: clear, accumulate, flush, CDF scan.
module histogram_denetleyici
  import histogram_denetleyici_pkg::*;
#(
  parameter int unsigned PIXEL_BIT    = PIXEL_BIT_VARSAYILAN,
  parameter int unsigned SAYAC_BIT    = SAYAC_BIT_VARSAYILAN,
  parameter int unsigned PIXEL_SAYISI = PIXEL_SAYISI_VARSAYILAN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baslat_i,
  input  logic                 pixel_gecerli_i,
  output logic                 hist_etkin_o,
  output logic                 hist_rstn_o,
  input  logic                 hist_hazir_i,
  input  logic [SAYAC_BIT-1:0] hist_cdf_min_i,
  input  logic                 hist_wr_en_i,
  input  logic                 hist_rd_en_i,
  input  logic [PIXEL_BIT-1:0] hist_addr_w_i,
  input  logic [PIXEL_BIT-1:0] hist_addr_r_i,
  input  logic [SAYAC_BIT-1:0] hist_data_in_i,
  output logic [SAYAC_BIT-1:0] hist_data_out_o,
  output logic                 ram_wr_en_o,
  output logic                 ram_rd_en_o,
  output logic [PIXEL_BIT-1:0] ram_addr_w_o,
  output logic [PIXEL_BIT-1:0] ram_addr_r_o,
  output logic [SAYAC_BIT-1:0] ram_data_o,
  input  logic [SAYAC_BIT-1:0] ram_data_i,
  output logic                 cdf_gecerli_o,
  output logic [PIXEL_BIT-1:0] cdf_adres_o,
  output logic [SAYAC_BIT-1:0] cdf_deger_o,
  output logic [SAYAC_BIT-1:0] cdf_min_o,
  output logic                 mesgul_o,
  output logic                 bitti_o
);

  localparam int unsigned PS_BIT = $clog2(PIXEL_SAYISI + 1);

  durum_e               r_durum;
  logic [PIXEL_BIT-1:0] r_temiz_adres;
  logic [PS_BIT-1:0]    r_piksel_sayac;
  logic [SAYAC_BIT-1:0] r_cdf_min;
  logic                 r_bitti;

  logic                 w_piksel_kabul;
  logic                 w_tara_baslat;
  logic                 w_tara_bitti;
  logic                 w_tara_rd_en;
  logic                 w_tara_wr_en;
  logic [PIXEL_BIT-1:0] w_tara_addr_r;
  logic [PIXEL_BIT-1:0] w_tara_addr_w;
  logic [SAYAC_BIT-1:0] w_tara_data;

  assign w_piksel_kabul = (r_durum == StTopla) && pixel_gecerli_i;
  assign w_tara_baslat  = (r_durum == StBosalt) && hist_hazir_i;

  assign hist_etkin_o = w_piksel_kabul;
  // Histogram unit is held in reset by the global reset as well as by the HRST state.
  assign hist_rstn_o  = !rst_i && (r_durum != StHrst);
  assign mesgul_o     = (r_durum != StBosta);
  assign bitti_o      = r_bitti;
  assign cdf_min_o    = r_cdf_min;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum        <= StBosta;
      r_temiz_adres  <= '0;
      r_piksel_sayac <= '0;
      r_cdf_min      <= '0;
      r_bitti        <= LOW;
    end else begin
      r_bitti <= LOW;
      case (r_durum)
        StBosta: begin
          if (baslat_i) begin
            r_durum       <= StTemizle;
            r_temiz_adres <= '0;
          end
        end
        StTemizle: begin
          r_temiz_adres <= r_temiz_adres + 1'b1;
          if (r_temiz_adres == '1) begin
            r_durum <= StHrst;
          end
        end
        StHrst: begin
          r_piksel_sayac <= '0;
          r_durum        <= StTopla;
        end
        StTopla: begin
          if (w_piksel_kabul) begin
            r_piksel_sayac <= r_piksel_sayac + 1'b1;
            if (r_piksel_sayac == PS_BIT'(PIXEL_SAYISI - 1)) begin
              r_durum <= StBosalt;
            end
          end
        end
        StBosalt: begin
          if (hist_hazir_i) begin
            r_cdf_min <= hist_cdf_min_i;
            r_durum   <= StTara;
          end
        end
        StTara: begin
          if (w_tara_bitti) begin
            r_bitti <= HIGH;
            r_durum <= StBitti;
          end
        end
        StBitti: begin
          r_durum <= StBosta;
        end
        default: begin
          r_durum <= StBosta;
        end
      endcase
    end
  end

  // RAM port ownership: each state selects exactly one driver; idle means both enables high.
  always_comb begin
    ram_wr_en_o     = HIGH;
    ram_rd_en_o     = HIGH;
    ram_addr_w_o    = '0;
    ram_addr_r_o    = '0;
    ram_data_o      = '0;
    hist_data_out_o = '0;
    case (r_durum)
      StTemizle: begin
        ram_wr_en_o  = LOW;
        ram_addr_w_o = r_temiz_adres;
      end
      StTopla, StBosalt: begin
        ram_wr_en_o     = hist_wr_en_i;
        ram_rd_en_o     = hist_rd_en_i;
        ram_addr_w_o    = hist_addr_w_i;
        ram_addr_r_o    = hist_addr_r_i;
        ram_data_o      = hist_data_in_i;
        hist_data_out_o = ram_data_i;
      end
      StTara: begin
        ram_wr_en_o  = w_tara_wr_en;
        ram_rd_en_o  = w_tara_rd_en;
        ram_addr_w_o = w_tara_addr_w;
        ram_addr_r_o = w_tara_addr_r;
        ram_data_o   = w_tara_data;
      end
      default: begin
      end
    endcase
  end

  histogram_denetleyici_tara_birimi #(
    .PIXEL_BIT (PIXEL_BIT),
    .SAYAC_BIT (SAYAC_BIT)
  ) u_tara (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_baslat      (w_tara_baslat),
    .i_ram_veri    (ram_data_i),
    .o_ram_rd_en   (w_tara_rd_en),
    .o_ram_addr_r  (w_tara_addr_r),
    .o_ram_wr_en   (w_tara_wr_en),
    .o_ram_addr_w  (w_tara_addr_w),
    .o_ram_data    (w_tara_data),
    .o_cdf_gecerli (cdf_gecerli_o),
    .o_cdf_adres   (cdf_adres_o),
    .o_cdf_deger   (cdf_deger_o),
    .o_bitti       (w_tara_bitti)
  );

endmodule

// File: tb/tb_histogram_denetleyici.sv
// Directed bench: RAM model, scripted histogram unit, full-frame CDF checks.
module tb_histogram_denetleyici;

  localparam int N      = 512;
  localparam int SATMAX = 131071;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        baslat_i = 1'b0;
  logic        pixel_gecerli_i = 1'b0;
  logic        hist_hazir_i = 1'b0;
  logic [16:0] hist_cdf_min_i = '0;
  logic        hist_wr_en_i = 1'b1;
  logic        hist_rd_en_i = 1'b1;
  logic [7:0]  hist_addr_w_i = '0;
  logic [7:0]  hist_addr_r_i = '0;
  logic [16:0] hist_data_in_i = '0;
  logic [16:0] ram_data_i = '0;

  logic        hist_etkin_o, hist_rstn_o, ram_wr_en_o, ram_rd_en_o;
  logic        cdf_gecerli_o, mesgul_o, bitti_o;
  logic [16:0] hist_data_out_o, ram_data_o, cdf_deger_o, cdf_min_o;
  logic [7:0]  ram_addr_w_o, ram_addr_r_o, cdf_adres_o;

  logic [16:0] mem [256];
  logic [7:0]  px = '0;
  logic        mon_clr = 1'b0;
  int          ucnt [256];
  int          fwd = 0;
  int          n_wr = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk_i = ~clk_i;

  histogram_denetleyici #(
    .PIXEL_BIT    (8),
    .SAYAC_BIT    (17),
    .PIXEL_SAYISI (N)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .baslat_i        (baslat_i),
    .pixel_gecerli_i (pixel_gecerli_i),
    .hist_etkin_o    (hist_etkin_o),
    .hist_rstn_o     (hist_rstn_o),
    .hist_hazir_i    (hist_hazir_i),
    .hist_cdf_min_i  (hist_cdf_min_i),
    .hist_wr_en_i    (hist_wr_en_i),
    .hist_rd_en_i    (hist_rd_en_i),
    .hist_addr_w_i   (hist_addr_w_i),
    .hist_addr_r_i   (hist_addr_r_i),
    .hist_data_in_i  (hist_data_in_i),
    .hist_data_out_o (hist_data_out_o),
    .ram_wr_en_o     (ram_wr_en_o),
    .ram_rd_en_o     (ram_rd_en_o),
    .ram_addr_w_o    (ram_addr_w_o),
    .ram_addr_r_o    (ram_addr_r_o),
    .ram_data_o      (ram_data_o),
    .ram_data_i      (ram_data_i),
    .cdf_gecerli_o   (cdf_gecerli_o),
    .cdf_adres_o     (cdf_adres_o),
    .cdf_deger_o     (cdf_deger_o),
    .cdf_min_o       (cdf_min_o),
    .mesgul_o        (mesgul_o),
    .bitti_o         (bitti_o)
  );

  // Synchronous RAM, read data one cycle after the read.
  always @(posedge clk_i) begin
    if (!ram_wr_en_o) begin
      mem[ram_addr_w_o] <= ram_data_o;
      n_wr <= n_wr + 1;
    end
    if (!ram_rd_en_o) ram_data_i <= mem[ram_addr_r_o];
  end

  // Pixels the histogram unit actually sees.
  always @(posedge clk_i) begin
    if (mon_clr) begin
      fwd <= 0;
      for (int b = 0; b < 256; b++) ucnt[b] <= 0;
    end else if (hist_etkin_o) begin
      fwd <= fwd + 1;
      ucnt[px] <= ucnt[px] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int wval_of(input int mode, input int b);
    case (mode)
      0:       return (b == 7) ? N : 0;
      1:       return 2;
      2:       return (b < 4) ? N / 4 : 0;
      3:       return (b < 2) ? 100000 : ((b == 200) ? N : 0);
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] pix_of(input int mode, input int idx);
    case (mode)
      0:       return 8'd7;
      1:       return 8'(idx / 2);
      2:       return 8'(idx % 4);
      default: return 8'd200;
    endcase
  endfunction

  task automatic run_frame(input int mode);
    int wv [256];
    int expc [256];
    int cum, e, cyc, nval, first, last, bitti_at, bitti_cnt, e_a, e_d, e_wb, pb;
    cum = 0;
    for (int b = 0; b < 256; b++) begin
      wv[b] = wval_of(mode, b);
      cum = cum + wv[b];
      if (cum > SATMAX) cum = SATMAX;
      expc[b] = cum;
    end
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    pixel_gecerli_i = 1'b1;
    baslat_i = 1'b1;
    step();
    baslat_i = 1'b0;
    e = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_i);
      if (ram_wr_en_o !== 1'b0 || ram_addr_w_o !== 8'(i) || ram_data_o !== '0 ||
          hist_etkin_o !== 1'b0) e++;
      step();
    end
    pixel_gecerli_i = 1'b0;
    @(negedge clk_i);
    chk("clr_seq", 32'(e), 0);
    chk("hrst_low", 32'(hist_rstn_o), 0);
    chk("hrst_nowr", 32'(ram_wr_en_o), 1);
    chk("clr_drop", 32'(fwd), 0);
    step();
    @(negedge clk_i);
    chk("topla_rstn", 32'(hist_rstn_o), 1);
    cyc = 0;
    while (fwd < N && cyc < 4 * N) begin
      px = pix_of(mode, fwd);
      pixel_gecerli_i = (mode != 2) || (cyc % 3 != 0);
      step();
      cyc++;
    end
    pixel_gecerli_i = 1'b1;
    chk("feed_cnt", 32'(fwd), 32'(N));
    @(negedge clk_i);
    chk("bosalt_etkin", 32'(hist_etkin_o), 0);
    chk("bosalt_busy", 32'(mesgul_o), 1);
    for (int b = 0; b < 256; b++) begin
      hist_wr_en_i = 1'b0;
      hist_addr_w_i = 8'(b);
      hist_data_in_i = 17'(wv[b]);
      step();
    end
    hist_wr_en_i = 1'b1;
    chk("bosalt_drop", 32'(fwd), 32'(N));
    if (mode < 3) begin
      e = 0;
      for (int b = 0; b < 256; b++) if (ucnt[b] != wv[b]) e++;
      chk("fwd_bins", 32'(e), 0);
    end
    pb = (mode == 3) ? 1 : ((mode == 2) ? 3 : 7);
    hist_rd_en_i = 1'b0;
    hist_addr_r_i = 8'(pb);
    step();
    hist_rd_en_i = 1'b1;
    @(negedge clk_i);
    chk("rd_pass", 32'(hist_data_out_o), 32'(wv[pb]));
    hist_cdf_min_i = 17'(1000 + mode);
    hist_hazir_i = 1'b1;
    step();
    hist_hazir_i = 1'b0;
    baslat_i = (mode == 1);
    nval = 0; first = -1; last = -1; bitti_at = -1; bitti_cnt = 0;
    e_a = 0; e_d = 0; e_wb = 0;
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk_i);
      if (c == 5) baslat_i = 1'b0;
      if (c == 1) chk("cdf_min", 32'(cdf_min_o), 32'(1000 + mode));
      if (cdf_gecerli_o) begin
        if (first < 0) first = c;
        last = c;
        if (nval < 256) begin
          if (cdf_adres_o !== 8'(nval)) e_a++;
          if (cdf_deger_o !== 17'(expc[nval])) e_d++;
          if (ram_wr_en_o !== 1'b0 || ram_addr_w_o !== 8'(nval) ||
              ram_data_o !== 17'(expc[nval])) e_wb++;
        end
        nval++;
      end
      if (bitti_o) begin
        bitti_cnt++;
        bitti_at = c;
      end
    end
    chk("tara_first", 32'(first), 3);
    chk("tara_last", 32'(last), 258);
    chk("tara_count", 32'(nval), 256);
    chk("cdf_adres", 32'(e_a), 0);
    chk("cdf_deger", 32'(e_d), 0);
    chk("writeback", 32'(e_wb), 0);
    chk("bitti_at", 32'(bitti_at), 259);
    chk("bitti_len", 32'(bitti_cnt), 1);
    chk("idle_after", 32'(mesgul_o), 0);
    e = 0;
    for (int b = 0; b < 256; b++) if (mem[b] !== 17'(expc[b])) e++;
    chk("ram_cdf", 32'(e), 0);
    chk("ram_255", 32'(mem[255]), 32'(expc[255]));
    pixel_gecerli_i = 1'b0;
  endtask

  initial begin
    int w0;
    repeat (3) step();
    @(negedge clk_i);
    chk("rst_wr_en", 32'(ram_wr_en_o), 1);
    chk("rst_rd_en", 32'(ram_rd_en_o), 1);
    chk("rst_addrs", 32'({ram_addr_w_o, ram_addr_r_o, cdf_adres_o}), 0);
    chk("rst_data", 32'(ram_data_o | cdf_deger_o | cdf_min_o | hist_data_out_o), 0);
    chk("rst_flags", 32'({cdf_gecerli_o, mesgul_o, bitti_o, hist_etkin_o}), 0);
    chk("rst_hrstn", 32'(hist_rstn_o), 0);
    rst_i = 1'b0;
    pixel_gecerli_i = 1'b1;
    repeat (6) step();
    @(negedge clk_i);
    chk("idle_etkin", 32'(hist_etkin_o), 0);
    chk("idle_hrstn", 32'(hist_rstn_o), 1);
    chk("idle_en", 32'({ram_wr_en_o, ram_rd_en_o}), 3);
    chk("idle_busy", 32'(mesgul_o), 0);
    pixel_gecerli_i = 1'b0;

    run_frame(0);
    run_frame(1);

    // Abort in the middle of pixel accumulation while the unit is writing.
    baslat_i = 1'b1;
    step();
    baslat_i = 1'b0;
    repeat (258) step();
    px = 8'd3;
    pixel_gecerli_i = 1'b1;
    hist_wr_en_i = 1'b0;
    hist_addr_w_i = 8'd9;
    hist_data_in_i = 17'd55;
    repeat (5) step();
    @(negedge clk_i);
    chk("abort_busy_pre", 32'(mesgul_o), 1);
    chk("abort_wr_pre", 32'(ram_wr_en_o), 0);
    rst_i = 1'b1;
    #1;
    chk("abort_busy", 32'(mesgul_o), 0);
    chk("abort_hrstn", 32'(hist_rstn_o), 0);
    chk("abort_wr_en", 32'(ram_wr_en_o), 1);
    chk("abort_etkin", 32'(hist_etkin_o), 0);
    w0 = n_wr;
    repeat (3) step();
    chk("abort_nowr", 32'(n_wr), 32'(w0));
    hist_wr_en_i = 1'b1;
    pixel_gecerli_i = 1'b0;
    rst_i = 1'b0;
    step();

    run_frame(2);
    run_frame(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/histogram_denetleyici.md
# histogram_denetleyici

Frame-level sequencer and RAM-port owner for the histogram equalisation path. Sits between the pixel stream, the histogram accumulation unit and the 256-entry histogram RAM. Per frame it:
- clears the RAM;
- resets the histogram unit;
- gates one frame of pixels into that unit while forwarding its RAM traffic;
- scans the finished histogram to produce a cumulative (CDF) stream, writing each CDF value back into the RAM in place.

## Interface
Parameters:
- PIXEL_BIT, 8, pixel width; RAM address width
- SAYAC_BIT, 17, bin/CDF count width
- PIXEL_SAYISI, 76800, pixels per frame

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- baslat_i  in  1  start-frame pulse
- pixel_gecerli_i  in  1  pixel stream valid
- hist_etkin_o  out  1  enable to histogram unit
- hist_rstn_o  out  1  active-low reset to histogram unit
- hist_hazir_i  in  1  histogram unit flush complete
- hist_cdf_min_i  in  SAYAC_BIT  histogram unit minimum-bin count
- hist_wr_en_i, hist_rd_en_i  in  1  histogram unit RAM enables, active-low
- hist_addr_w_i, hist_addr_r_i  in  PIXEL_BIT  histogram unit RAM addresses
- hist_data_in_i  in  SAYAC_BIT  histogram unit write data
- hist_data_out_o  out  SAYAC_BIT  RAM read data returned to histogram unit
- ram_wr_en_o, ram_rd_en_o  out  1  RAM enables, active-low
- ram_addr_w_o, ram_addr_r_o  out  PIXEL_BIT  RAM addresses
- ram_data_o  out  SAYAC_BIT  RAM write data
- ram_data_i  in  SAYAC_BIT  RAM read data, valid 1 cycle after read
- cdf_gecerli_o  out  1  CDF output valid
- cdf_adres_o  out  PIXEL_BIT  bin index of CDF output
- cdf_deger_o  out  SAYAC_BIT  cumulative count
- cdf_min_o  out  SAYAC_BIT  latched minimum-bin count
- mesgul_o  out  1  busy, high in any state except BOSTA
- bitti_o  out  1  frame-done pulse

## Operation
- States: BOSTA → TEMIZLE → HRST → TOPLA → BOSALT → TARA → BITTI → BOSTA.
- BOSTA:
  - ram enables high (inactive); hist_rstn_o=1.
  - baslat_i=1 → TEMIZLE, address counter=0.
- TEMIZLE:
  - ram_wr_en_o=0, ram_addr_w_o=counter, ram_data_o=0.
  - After address 255 → HRST; the 8-bit counter wraps.
- HRST: hist_rstn_o=0 for exactly 1 cycle → TOPLA; pixel counter=0.
- TOPLA:
  - hist_etkin_o=pixel_gecerli_i.
  - All hist_* RAM signals pass combinationally to ram_*; ram_data_i passes to hist_data_out_o.
  - Each accepted pixel increments the pixel counter.
  - On the cycle the PIXEL_SAYISI-th pixel is accepted → BOSALT.
- BOSALT:
  - hist_etkin_o=0; pass-through continues so the unit's 3 flush writes reach the RAM.
  - hist_hazir_i=1 → TARA; latch hist_cdf_min_i into cdf_min_o.
- TARA:
  - Issue reads at addresses 0..255, one per cycle.
  - Data returns next cycle; accumulator += ram_data_i, saturating at 2^SAYAC_BIT−1.
  - Registered result drives cdf_deger_o/cdf_adres_o with cdf_gecerli_o=1.
  - In the same cycle, ram_wr_en_o=0 writes cdf_deger_o back to cdf_adres_o.
  - After bin 255 is output → BITTI.
- BITTI: bitti_o=1 for 1 cycle → BOSTA. RAM contents then hold the CDF.
- pixel_gecerli_i outside TOPLA: dropped; hist_etkin_o=0.
- baslat_i outside BOSTA: ignored.

## Timing
- Reset values: state BOSTA; ram_wr_en_o=ram_rd_en_o=1; all addresses, data, CDF outputs and cdf_min_o=0; cdf_gecerli_o=mesgul_o=bitti_o=hist_etkin_o=0.
- hist_rstn_o = !rst_i & !(state==HRST), combinational. The histogram unit therefore stays reset while rst_i is high.
- TEMIZLE lasts exactly 256 cycles; HRST lasts 1.
- TARA read issued at cycle n → cdf_gecerli_o at n+2. TARA lasts 258 cycles; CDF outputs appear on cycles 3..258.
- cdf_deger_o for bin 255 = total of all bins (76800 for a full frame); cdf_gecerli_o is high for exactly 256 consecutive cycles.
- A TARA-phase write at address k and a read at address k+2 in the same cycle do not collide.
- rst_i mid-frame: immediate return to BOSTA; no further RAM writes. A subsequent baslat_i performs the full clear.

## Structure
- Shared package (sabitler.vh): state encodings, HIGH/LOW, PIXEL_BIT, PIXEL_SAYISI.
- Sub-module tara_birimi: read-address counter, 1-cycle data alignment, saturating accumulator, write-back. Enabled by the FSM; returns a done pulse.
- The FSM, clear counter, pixel counter and TOPLA muxing stay in the top level.

## Test plan
- Reset then idle: all outputs hold reset values; ram enables stay 1; baslat_i mid-TARA is ignored.
- Clear: baslat_i → 256 consecutive writes of 0 at addresses 0..255, then hist_rstn_o=0 for one cycle.
- Full frame, model unit, all pixels 7 → cdf_deger_o=0 for bins 0..6, then 76800 from bin 7 through 255; cdf_min_o=76800; RAM[255]=76800.
- Ramp frame (300 each of values 0..255) → cdf_deger_o at bin k = 300·(k+1); bitti_o pulses 1 cycle after the bin-255 output.
- Gapped pixel_gecerli_i and pixels arriving during TEMIZLE/BOSALT → only PIXEL_SAYISI pixels are forwarded; the rest are dropped.
- rst_i asserted mid-TOPLA → state BOSTA next edge, hist_rstn_o=0, no RAM write. A new baslat_i completes a correct frame.
